text_console: RTL and testbench

- Character-stream front end for the VGA text display. It accepts a byte stream (ASCII plus control codes) over a valid/ready handshake.
- It tracks a cursor and performs clear-screen and clear-line sweeps.
- It emits one character-cell write per cycle on the display's char-write interface (charWr, colours, code, X, Y).
- It is the sole writer of the display's character RAM and sits directly upstream of the VGA text block.

---
 rtl/text_console.sv | 190 +++++++++++++++++++
 tb/tb_text_console.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// Byte-stream front end for the VGA text display: tracks the cursor, runs clear-screen and
// clear-line sweeps, and issues at most one registered character-cell write per cycle.
module text_console #(
  parameter int          COLS   = 64,
  parameter int          ROWS   = 24,
  parameter logic [23:0] DEF_FG = 24'hFFFFFF,
  parameter logic [23:0] DEF_BG = 24'h000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        inValid,
  input  logic [7:0]  inByte,
  output logic        inReady,
  input  logic        colorWr,
  input  logic [23:0] fgIn,
  input  logic [23:0] bgIn,
  output logic        charWr,
  output logic [23:0] charWrFgColor,
  output logic [23:0] charWrBgColor,
  output logic [7:0]  charWrCode,
  output logic [5:0]  charWrX,
  output logic [4:0]  charWrY,
  output logic [5:0]  cursorX,
  output logic [4:0]  cursorY,
  output logic        busy
);
  localparam logic [5:0] X_MAX = 6'(COLS - 1);
  localparam logic [4:0] Y_MAX = 5'(ROWS - 1);
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {IDLE, CLEAR_SCREEN, CLEAR_LINE} state_e;

  state_e      state_q, state_d;
  logic [5:0]  sx_q, sx_d, cx_q, cx_d, wx_q, wx_d;
  logic [4:0]  sy_q, sy_d, cy_q, cy_d, wy_q, wy_d;
  logic [23:0] fg_q, fg_d, bg_q, bg_d, wfg_q, wfg_d, wbg_q, wbg_d;
  logic [7:0]  code_q, code_d;
  logic        wr_q, wr_d, rdy_q, rdy_d, busy_q, busy_d;
  logic        do_nl;
  logic [4:0]  cy_next;

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    wr_d    = 1'b0;
    code_d  = code_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    wfg_d   = wfg_q;
    wbg_d   = wbg_q;
    do_nl   = 1'b0;
    // Explicit wrap: ROWS is not a power of two.
    cy_next = (cy_q == Y_MAX) ? 5'd0 : cy_q + 5'd1;

    unique case (state_q)
      CLEAR_SCREEN: begin
        wr_d   = 1'b1;
        code_d = SPACE;
        wx_d   = sx_q;
        wy_d   = sy_q;
        if (sx_q == X_MAX) begin
          sx_d = 6'd0;
          if (sy_q == Y_MAX) begin
            sy_d    = 5'd0;
            cx_d    = 6'd0;
            cy_d    = 5'd0;
            state_d = IDLE;
          end else begin
            sy_d = sy_q + 5'd1;
          end
        end else begin
          sx_d = sx_q + 6'd1;
        end
      end
      CLEAR_LINE: begin
        wr_d   = 1'b1;
        code_d = SPACE;
        wx_d   = sx_q;
        wy_d   = cy_q;
        if (sx_q == X_MAX) begin
          sx_d    = 6'd0;
          state_d = IDLE;
        end else begin
          sx_d = sx_q + 6'd1;
        end
      end
      default: begin
        if (inValid && rdy_q) begin
          if (inByte >= SPACE) begin
            wr_d   = 1'b1;
            code_d = inByte;
            wx_d   = cx_q;
            wy_d   = cy_q;
            if (cx_q == X_MAX) do_nl = 1'b1;
            else               cx_d  = cx_q + 6'd1;
          end else begin
            case (inByte)
              8'h0A: do_nl = 1'b1;
              8'h0D: cx_d = 6'd0;
              8'h08: begin
                if (cx_q != 6'd0) begin
                  cx_d   = cx_q - 6'd1;
                  wr_d   = 1'b1;
                  code_d = SPACE;
                  wx_d   = cx_q - 6'd1;
                  wy_d   = cy_q;
                end
              end
              8'h0C: begin
                cx_d    = 6'd0;
                cy_d    = 5'd0;
                sx_d    = 6'd0;
                sy_d    = 5'd0;
                state_d = CLEAR_SCREEN;
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    if (do_nl) begin
      cx_d    = 6'd0;
      cy_d    = cy_next;
      sx_d    = 6'd0;
      state_d = CLEAR_LINE;
    end

    // Writes use the colours held before this edge; a same-cycle colorWr lands afterwards.
    if (wr_d) begin
      wfg_d = fg_q;
      wbg_d = bg_q;
    end
    fg_d   = colorWr ? fgIn : fg_q;
    bg_d   = colorWr ? bgIn : bg_q;
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR_SCREEN;
      sx_q    <= 6'd0;
      sy_q    <= 5'd0;
      cx_q    <= 6'd0;
      cy_q    <= 5'd0;
      wr_q    <= 1'b0;
      code_q  <= 8'd0;
      wx_q    <= 6'd0;
      wy_q    <= 5'd0;
      wfg_q   <= 24'd0;
      wbg_q   <= 24'd0;
      fg_q    <= DEF_FG;
      bg_q    <= DEF_BG;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      wr_q    <= wr_d;
      code_q  <= code_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wfg_q   <= wfg_d;
      wbg_q   <= wbg_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign inReady       = rdy_q;
  assign busy          = busy_q;
  assign charWr        = wr_q;
  assign charWrCode    = code_q;
  assign charWrX       = wx_q;
  assign charWrY       = wy_q;
  assign charWrFgColor = wfg_q;
  assign charWrBgColor = wbg_q;
  assign cursorX       = cx_q;
  assign cursorY       = cy_q;
endmodule

// File: tb/tb_text_console.sv
// Randomised bench for text_console against a queue-based screen/cursor model, plus directed cases.
module tb_text_console;
  localparam int COLS = 64;
  localparam int ROWS = 24;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic        inValid  = 1'b0;
  logic [7:0]  inByte   = 8'd0;
  logic        colorWr  = 1'b0;
  logic [23:0] fgIn     = 24'd0;
  logic [23:0] bgIn     = 24'd0;
  logic        inReady, charWr, busy;
  logic [23:0] charWrFgColor, charWrBgColor;
  logic [7:0]  charWrCode;
  logic [5:0]  charWrX, cursorX;
  logic [4:0]  charWrY, cursorY;

  text_console dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .inValid(inValid), .inByte(inByte), .inReady(inReady),
    .colorWr(colorWr), .fgIn(fgIn), .bgIn(bgIn), .charWr(charWr),
    .charWrFgColor(charWrFgColor), .charWrBgColor(charWrBgColor), .charWrCode(charWrCode),
    .charWrX(charWrX), .charWrY(charWrY), .cursorX(cursorX), .cursorY(cursorY), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int acc_cnt  = 0;
  bit chk_en   = 0;
  bit rnd_col  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending sweep cells in a queue, cursor as plain integers.
  typedef struct { logic [7:0] code; int x; int y; } cell_t;
  cell_t pend[$];

  logic        m_wr, m_ready, m_busy;
  logic [7:0]  m_code;
  logic [23:0] m_fg, m_bg, m_wfg, m_wbg;
  int          m_x, m_y, m_cx, m_cy;

  task automatic push_row(input int y);
    for (int x = 0; x < COLS; x++) pend.push_back('{8'h20, x, y});
  endtask

  task automatic push_screen();
    for (int y = 0; y < ROWS; y++) push_row(y);
  endtask

  task automatic emit(input logic [7:0] code, input int x, input int y);
    m_wr = 1'b1; m_code = code; m_x = x; m_y = y; m_wfg = m_fg; m_wbg = m_bg;
  endtask

  task automatic newline();
    m_cx = 0;
    m_cy = (m_cy + 1) % ROWS;
    push_row(m_cy);
  endtask

  task automatic handle_byte(input logic [7:0] b);
    if (b >= 8'h20) begin
      emit(b, m_cx, m_cy);
      if (m_cx == COLS - 1) newline();
      else m_cx++;
    end else if (b == 8'h0A) newline();
    else if (b == 8'h0D) m_cx = 0;
    else if (b == 8'h08) begin
      if (m_cx > 0) begin m_cx--; emit(8'h20, m_cx, m_cy); end
    end else if (b == 8'h0C) begin
      m_cx = 0; m_cy = 0; push_screen();
    end
  endtask

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m_wr = 0; m_code = 0; m_x = 0; m_y = 0; m_wfg = 0; m_wbg = 0;
      m_cx = 0; m_cy = 0; m_fg = 24'hFFFFFF; m_bg = 24'h000000;
      m_ready = 0; m_busy = 1;
      pend.delete();
      push_screen();
    end else begin : step
      cell_t c;
      m_wr = 1'b0;
      if (pend.size() > 0) begin
        c = pend.pop_front();
        emit(c.code, c.x, c.y);
      end else if (m_ready && inValid) begin
        acc_cnt++;
        handle_byte(inByte);
      end
      if (colorWr) begin m_fg = fgIn; m_bg = bgIn; end
      m_ready = (pend.size() == 0);
      m_busy  = !m_ready;
    end
  end

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("charWr",  32'(charWr), 32'(m_wr));
      chk("code",    32'(charWrCode), 32'(m_code));
      chk("wrX",     32'(charWrX), 32'(m_x));
      chk("wrY",     32'(charWrY), 32'(m_y));
      chk("wrFg",    32'(charWrFgColor), 32'(m_wfg));
      chk("wrBg",    32'(charWrBgColor), 32'(m_wbg));
      chk("cursorX", 32'(cursorX), 32'(m_cx));
      chk("cursorY", 32'(cursorY), 32'(m_cy));
      chk("inReady", 32'(inReady), 32'(m_ready));
      chk("busy",    32'(busy), 32'(m_busy));
      if (charWr) wr_cnt++;
    end
  end

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLOCK_50); #1;
      if (inReady) begin ok = 1; break; end
    end
    chk("idle_within_budget", 32'(ok), 32'd1);
    @(negedge CLOCK_50); #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    bit ok;
    n = acc_cnt;
    ok = 0;
    inValid = 1'b1;
    inByte  = b;
    for (int i = 0; i < 3000; i++) begin
      if (rnd_col) begin
        colorWr = ($urandom_range(0, 7) == 0);
        fgIn    = 24'($urandom);
        bgIn    = 24'($urandom);
      end
      @(posedge CLOCK_50); #1;
      if (acc_cnt != n) begin ok = 1; break; end
    end
    chk("accept_within_budget", 32'(ok), 32'd1);
    inValid = 1'b0;
    colorWr = 1'b0;
    @(negedge CLOCK_50); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, r;
    logic [7:0] b;
    #1 reset = 1'b1;
    #1 chk_en = 1;
    repeat (3) @(negedge CLOCK_50);
    #1;
    chk("rst_charWr", 32'(charWr), 32'd0);
    chk("rst_inReady", 32'(inReady), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    @(negedge CLOCK_50);
    reset = 1'b0;

    wait_idle(3000);
    chk("init_clear_count", 32'(wr_cnt), 32'd1536);
    chk("init_last_x", 32'(charWrX), 32'd63);
    chk("init_last_y", 32'(charWrY), 32'd23);
    chk("init_busy", 32'(busy), 32'd0);

    send(8'h41);
    chk("A_code", 32'(charWrCode), 32'h41);
    send(8'h42);
    chk("B_code", 32'(charWrCode), 32'h42);
    chk("B_x", 32'(charWrX), 32'd1);
    chk("AB_cursorX", 32'(cursorX), 32'd2);

    send(8'h0D);
    repeat (5) send(8'h0A);
    repeat (63) send(8'($urandom_range(33, 126)));
    chk("pre_Z_cursorX", 32'(cursorX), 32'd63);
    chk("pre_Z_cursorY", 32'(cursorY), 32'd5);
    snap = wr_cnt;
    send(8'h5A);
    chk("Z_code", 32'(charWrCode), 32'h5A);
    chk("Z_x", 32'(charWrX), 32'd63);
    chk("Z_y", 32'(charWrY), 32'd5);
    chk("Z_cursorY", 32'(cursorY), 32'd6);
    chk("Z_inReady", 32'(inReady), 32'd0);
    wait_idle(200);
    chk("Z_write_count", 32'(wr_cnt - snap), 32'd65);
    chk("Z_last_row", 32'(charWrY), 32'd6);

    repeat (17) send(8'h0A);
    repeat (10) send(8'($urandom_range(33, 126)));
    chk("pre_LF_cursorY", 32'(cursorY), 32'd23);
    snap = wr_cnt;
    send(8'h0A);
    chk("LF_no_charwrite", 32'(charWr), 32'd0);
    chk("LF_cursorY", 32'(cursorY), 32'd0);
    wait_idle(200);
    chk("LF_write_count", 32'(wr_cnt - snap), 32'd64);
    chk("LF_cleared_row", 32'(charWrY), 32'd0);
    send(8'h08);
    chk("BS0_no_write", 32'(charWr), 32'd0);
    chk("BS0_cursorX", 32'(cursorX), 32'd0);

    inValid = 1'b1; inByte = 8'h43; colorWr = 1'b1;
    fgIn = 24'hFF0000; bgIn = 24'h0000FF;
    @(posedge CLOCK_50); #1;
    inValid = 1'b0; colorWr = 1'b0;
    chk("C_code", 32'(charWrCode), 32'h43);
    chk("C_old_fg", 32'(charWrFgColor), 32'hFFFFFF);
    chk("C_old_bg", 32'(charWrBgColor), 32'h000000);
    @(negedge CLOCK_50); #1;
    send(8'h44);
    chk("D_code", 32'(charWrCode), 32'h44);
    chk("D_new_fg", 32'(charWrFgColor), 32'hFF0000);
    chk("D_new_bg", 32'(charWrBgColor), 32'h0000FF);

    rnd_col = 1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
      r = $urandom_range(0, 199);
      if (r < 140)      b = 8'($urandom_range(32, 255));
      else if (r < 160) b = 8'h0A;
      else if (r < 170) b = 8'h0D;
      else if (r < 186) b = 8'h08;
      else if (r < 187) b = 8'h0C;
      else              b = 8'($urandom_range(0, 31));
      send(b);
    end
    rnd_col = 0;
    wait_idle(3000);

    send(8'h0C);
    repeat (700) @(negedge CLOCK_50);
    #2 reset = 1'b1;
    #1;
    chk("midrst_charWr", 32'(charWr), 32'd0);
    chk("midrst_inReady", 32'(inReady), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    snap = wr_cnt;
    wait_idle(3000);
    chk("post_rst_clear_count", 32'(wr_cnt - snap), 32'd1536);
    chk("post_rst_fg", 32'(charWrFgColor), 32'hFFFFFF);
    chk("post_rst_bg", 32'(charWrBgColor), 32'h000000);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
